mem_responder: RTL and testbench

Memory-side responder for the multi-cycle MIPS core: serves the core's instruction-fetch and data-memory ports from two on-chip word arrays, and collects the core's status stream. It also owns program/data preload, core reset release, a watchdog and post-run data readback. It sits between the testbench/host loader and the core, driving every core input except clock.

---
 rtl/mem_responder.sv | 219 +++++++++++++++++++++
 tb/tb_mem_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the multi-cycle MIPS core. Holds the
//   instruction and data word arrays the core runs from. Also owns program
//   and data preload, core reset release, a run watchdog, status-stream
//   collection and post-run data readback.
//
//   Ports
//     i_clk, i_rst_n          clock, asynchronous active-low reset
//     i_ld_*, o_ld_ready      preload write port (word index, LOAD only)
//     i_start, i_clear        LOAD->RUN and DONE->LOAD requests
//     o_core_rst_n            active-low reset driven to the core
//     i_i_addr, o_i_inst      core fetch port (byte address, 1-cycle latency)
//     i_d_*, o_d_rdata        core data port (byte address, read-first)
//     i_status, i_status_valid  core status stream
//     o_done, o_end_code, o_timeout, o_inst_cnt   run outcome
//     o_err, o_err_addr       first illegal core access of the run
//     i_dump_addr, o_dump_data  DMEM readback (word index, all states)
//
//   Handshake: preload has no backpressure. o_ld_ready is a level that is
//   high for the whole LOAD state; every cycle in which i_ld_valid is high
//   while o_ld_ready is high performs exactly one write at that clock edge.
//   Strobes seen outside LOAD are ignored.
module mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 64,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ld_valid,
  input  logic                  i_ld_sel,
  input  logic [ADDR_WIDTH-1:0] i_ld_addr,
  input  logic [DATA_WIDTH-1:0] i_ld_data,
  output logic                  o_ld_ready,
  input  logic                  i_start,
  input  logic                  i_clear,
  output logic                  o_core_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_i_addr,
  output logic [INST_WIDTH-1:0] o_i_inst,
  input  logic                  i_d_we,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  input  logic [DATA_WIDTH-1:0] i_d_wdata,
  output logic [DATA_WIDTH-1:0] o_d_rdata,
  input  logic [1:0]            i_status,
  input  logic                  i_status_valid,
  output logic                  o_done,
  output logic [1:0]            o_end_code,
  output logic                  o_timeout,
  output logic [31:0]           o_inst_cnt,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_err_addr,
  input  logic [ADDR_WIDTH-1:0] i_dump_addr,
  output logic [DATA_WIDTH-1:0] o_dump_data
);

  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);
  // Last count value of the watchdog: the edge that sees it ends RUN cycle MAX_CYCLES.
  localparam logic [31:0] WD_LAST = 32'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    core_rst_n_q, core_rst_n_d;
  logic [INST_WIDTH-1:0]   i_inst_q, i_inst_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
  logic [DATA_WIDTH-1:0]   dump_data_q, dump_data_d;
  logic                    done_q, done_d;
  logic [1:0]              end_code_q, end_code_d;
  logic                    timeout_q, timeout_d;
  logic [31:0]             inst_cnt_q, inst_cnt_d;
  logic [31:0]             cyc_q, cyc_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;

  logic [INST_WIDTH-1:0]   imem [IMEM_DEPTH];
  logic [DATA_WIDTH-1:0]   dmem [DMEM_DEPTH];

  // Address decode. Core ports carry byte addresses; preload and dump carry
  // word indices. An index is in range when every bit above the array's
  // index width is zero.
  logic                    i_legal, d_legal;
  logic [IMEM_AW-1:0]      i_idx;
  logic [DMEM_AW-1:0]      d_idx, dump_idx;
  logic                    ld_imem_ok, ld_dmem_ok, dump_ok;
  logic                    imem_we, dmem_we;
  logic [IMEM_AW-1:0]      imem_widx;
  logic [DMEM_AW-1:0]      dmem_widx;
  logic [DATA_WIDTH-1:0]   dmem_wdata;

  assign i_idx      = i_i_addr[IMEM_AW+1:2];
  assign d_idx      = i_d_addr[DMEM_AW+1:2];
  assign dump_idx   = i_dump_addr[DMEM_AW-1:0];
  assign i_legal    = (i_i_addr[1:0] == 2'b00) && (i_i_addr[ADDR_WIDTH-1:IMEM_AW+2] == '0);
  assign d_legal    = (i_d_addr[1:0] == 2'b00) && (i_d_addr[ADDR_WIDTH-1:DMEM_AW+2] == '0);
  assign ld_imem_ok = (i_ld_addr[ADDR_WIDTH-1:IMEM_AW] == '0);
  assign ld_dmem_ok = (i_ld_addr[ADDR_WIDTH-1:DMEM_AW] == '0);
  assign dump_ok    = (i_dump_addr[ADDR_WIDTH-1:DMEM_AW] == '0);

  // Preload and core writes live in disjoint states, so one DMEM write port
  // is shared between them.
  assign imem_we    = (state_q == ST_LOAD) && i_ld_valid && !i_ld_sel && ld_imem_ok;
  assign imem_widx  = i_ld_addr[IMEM_AW-1:0];
  assign dmem_we    = ((state_q == ST_LOAD) && i_ld_valid && i_ld_sel && ld_dmem_ok) ||
                      ((state_q == ST_RUN) && i_d_we && d_legal);
  assign dmem_widx  = (state_q == ST_LOAD) ? i_ld_addr[DMEM_AW-1:0] : d_idx;
  assign dmem_wdata = (state_q == ST_LOAD) ? i_ld_data : i_d_wdata;

  // Memory arrays carry no reset so they survive clear and reset.
  always_ff @(posedge i_clk) begin
    if (imem_we) imem[imem_widx] <= INST_WIDTH'(i_ld_data);
    if (dmem_we) dmem[dmem_widx] <= dmem_wdata;
  end

  always_comb begin
    state_d      = state_q;
    core_rst_n_d = (state_q == ST_RUN);
    i_inst_d     = i_legal ? imem[i_idx] : '0;
    d_rdata_d    = d_rdata_q;
    dump_data_d  = dump_ok ? dmem[dump_idx] : '0;
    done_d       = done_q;
    end_code_d   = end_code_q;
    timeout_d    = timeout_q;
    inst_cnt_d   = inst_cnt_q;
    cyc_d        = cyc_q;
    err_d        = err_q;
    err_addr_d   = err_addr_q;

    case (state_q)
      ST_LOAD: begin
        if (i_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Reads sample the array before this edge's write lands (read-first).
        d_rdata_d = d_legal ? dmem[d_idx] : '0;
        if (i_status_valid && !i_status[1]) inst_cnt_d = inst_cnt_q + 32'd1;
        // Only the first illegal access of a run is recorded; fetch wins a tie.
        if (!err_q && (!i_legal || !d_legal)) begin
          err_d      = 1'b1;
          err_addr_d = !i_legal ? i_i_addr : i_d_addr;
        end
        if (i_status_valid && i_status[1]) begin
          end_code_d = i_status;
          done_d     = 1'b1;
          state_d    = ST_DONE;
        end else if (cyc_q == WD_LAST) begin
          timeout_d  = 1'b1;
          done_d     = 1'b1;
          state_d    = ST_DONE;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      ST_DONE: begin
        if (i_clear) begin
          state_d    = ST_LOAD;
          done_d     = 1'b0;
          end_code_d = 2'd0;
          timeout_d  = 1'b0;
          inst_cnt_d = '0;
          cyc_d      = '0;
          err_d      = 1'b0;
          err_addr_d = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_LOAD;
      core_rst_n_q <= 1'b0;
      i_inst_q     <= '0;
      d_rdata_q    <= '0;
      dump_data_q  <= '0;
      done_q       <= 1'b0;
      end_code_q   <= 2'd0;
      timeout_q    <= 1'b0;
      inst_cnt_q   <= '0;
      cyc_q        <= '0;
      err_q        <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      core_rst_n_q <= core_rst_n_d;
      i_inst_q     <= i_inst_d;
      d_rdata_q    <= d_rdata_d;
      dump_data_q  <= dump_data_d;
      done_q       <= done_d;
      end_code_q   <= end_code_d;
      timeout_q    <= timeout_d;
      inst_cnt_q   <= inst_cnt_d;
      cyc_q        <= cyc_d;
      err_q        <= err_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign o_ld_ready   = (state_q == ST_LOAD);
  assign o_core_rst_n = core_rst_n_q;
  assign o_i_inst     = i_inst_q;
  assign o_d_rdata    = d_rdata_q;
  assign o_dump_data  = dump_data_q;
  assign o_done       = done_q;
  assign o_end_code   = end_code_q;
  assign o_timeout    = timeout_q;
  assign o_inst_cnt   = inst_cnt_q;
  assign o_err        = err_q;
  assign o_err_addr   = err_addr_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_ld_valid = 1'b0;
  logic        i_ld_sel = 1'b0;
  logic [31:0] i_ld_addr = '0;
  logic [31:0] i_ld_data = '0;
  logic        o_ld_ready;
  logic        i_start = 1'b0;
  logic        i_clear = 1'b0;
  logic        o_core_rst_n;
  logic [31:0] i_i_addr = '0;
  logic [31:0] o_i_inst;
  logic        i_d_we = 1'b0;
  logic [31:0] i_d_addr = '0;
  logic [31:0] i_d_wdata = '0;
  logic [31:0] o_d_rdata;
  logic [1:0]  i_status = '0;
  logic        i_status_valid = 1'b0;
  logic        o_done;
  logic [1:0]  o_end_code;
  logic        o_timeout;
  logic [31:0] o_inst_cnt;
  logic        o_err;
  logic [31:0] o_err_addr;
  logic [31:0] i_dump_addr = '0;
  logic [31:0] o_dump_data;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] imem_m [256];
  logic [31:0] dmem_m [64];

  mem_responder #(
    .ADDR_WIDTH(32), .INST_WIDTH(32), .DATA_WIDTH(32),
    .IMEM_DEPTH(256), .DMEM_DEPTH(64), .MAX_CYCLES(20)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ld_valid(i_ld_valid), .i_ld_sel(i_ld_sel), .i_ld_addr(i_ld_addr),
    .i_ld_data(i_ld_data), .o_ld_ready(o_ld_ready),
    .i_start(i_start), .i_clear(i_clear), .o_core_rst_n(o_core_rst_n),
    .i_i_addr(i_i_addr), .o_i_inst(o_i_inst),
    .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata), .o_d_rdata(o_d_rdata),
    .i_status(i_status), .i_status_valid(i_status_valid),
    .o_done(o_done), .o_end_code(o_end_code), .o_timeout(o_timeout),
    .o_inst_cnt(o_inst_cnt), .o_err(o_err), .o_err_addr(o_err_addr),
    .i_dump_addr(i_dump_addr), .o_dump_data(o_dump_data)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ld(input logic sel, input logic [31:0] addr, input logic [31:0] data);
    i_ld_valid = 1'b1; i_ld_sel = sel; i_ld_addr = addr; i_ld_data = data;
    tick();
    i_ld_valid = 1'b0;
    if (sel && addr < 64) dmem_m[addr] = data;
    if (!sel && addr < 256) imem_m[addr] = data;
  endtask

  task automatic start_run();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic finish_run(input logic [1:0] code);
    i_status = code; i_status_valid = 1'b1;
    tick();
    i_status_valid = 1'b0; i_status = 2'd0;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst_n = 1'b0;
    #12;
    chk_cnt++; if (o_ld_ready !== 1'b1) $display("FAIL rst_ld_ready: got %0h exp 1", o_ld_ready); else pass_cnt++;
    chk_cnt++; if (o_core_rst_n !== 1'b0) $display("FAIL rst_core_rst_n: got %0h exp 0", o_core_rst_n); else pass_cnt++;
    chk_cnt++; if ({o_i_inst, o_d_rdata, o_dump_data} !== 96'h0) $display("FAIL rst_data_outs: got %h exp 0", {o_i_inst, o_d_rdata, o_dump_data}); else pass_cnt++;
    chk_cnt++; if ({o_done, o_end_code, o_timeout, o_err} !== 5'h0) $display("FAIL rst_flags: got %h exp 0", {o_done, o_end_code, o_timeout, o_err}); else pass_cnt++;
    chk_cnt++; if ({o_inst_cnt, o_err_addr} !== 64'h0) $display("FAIL rst_counts: got %h exp 0", {o_inst_cnt, o_err_addr}); else pass_cnt++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_preload_fetch();
    logic [31:0] got, exp;
    logic [31:0] dump_idx [8];
    ld(1'b1, 36, 32'h3636_3636);
    ld(1'b1, 100, 32'hFFFF_0000);   // out of range: dropped, must not alias onto 36
    ld(1'b0, 44, 32'h4444_4444);
    ld(1'b0, 300, 32'h0300_0300);   // out of range: dropped, must not alias onto 44
    ld(1'b0, 0, 32'h2001_0005);
    ld(1'b0, 1, 32'h8C22_000C);
    ld(1'b1, 0, 32'h0BAD_F00D);
    ld(1'b1, 2, 32'hAAAA_0000);
    ld(1'b1, 3, 32'hDEAD_BEEF);
    for (int i = 40; i < 48; i++) ld(1'b1, i, $urandom);
    // Readback in LOAD
    dump_idx = '{3, 36, 40, 41, 47, 0, 64, 100};
    for (int i = 0; i < 8; i++) begin
      i_dump_addr = dump_idx[i];
      exp_q.push_back(dump_idx[i] < 64 ? dmem_m[dump_idx[i]] : 32'h0);
      tick();
      got = o_dump_data; exp = exp_q.pop_front();
      chk_cnt++; if (got !== exp) $display("FAIL load_dump[%0d]: got %h exp %h", dump_idx[i], got, exp); else pass_cnt++;
    end
    // Preload write coinciding with start must still land
    i_ld_valid = 1'b1; i_ld_sel = 1'b0; i_ld_addr = 2; i_ld_data = 32'h2222_0002;
    start_run();
    imem_m[2] = 32'h2222_0002;
    chk_cnt++; if (o_core_rst_n !== 1'b0) $display("FAIL start_core_rst_lat: got %0h exp 0", o_core_rst_n); else pass_cnt++;
    chk_cnt++; if (o_ld_ready !== 1'b0) $display("FAIL run_ld_ready: got %0h exp 0", o_ld_ready); else pass_cnt++;
    // Preload attempt in RUN: ignored
    i_ld_sel = 1'b1; i_ld_addr = 3; i_ld_data = 32'h0;
    tick();
    i_ld_valid = 1'b0;
    chk_cnt++; if (o_core_rst_n !== 1'b1) $display("FAIL start_core_rst_rise: got %0h exp 1", o_core_rst_n); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: i_i_addr = 32'h0;
        1: i_i_addr = 32'h4;
        2: i_i_addr = 32'h8;
        default: i_i_addr = 32'hB0;
      endcase
      exp_q.push_back(imem_m[i_i_addr[9:2]]);
      tick();
      got = o_i_inst; exp = exp_q.pop_front();
      chk_cnt++; if (got !== exp) $display("FAIL fetch[%h]: got %h exp %h", i_i_addr, got, exp); else pass_cnt++;
    end
    i_i_addr = 32'h0;
    finish_run(2'd3);
  endtask

  task automatic test_data_path();
    logic [31:0] got, exp, val;
    int idx;
    start_run();
    // Write with same-cycle read: old data comes back
    i_d_we = 1'b1; i_d_addr = 32'h8; i_d_wdata = 32'h1234;
    exp_q.push_back(dmem_m[2]);
    dmem_m[2] = 32'h1234;
    tick();
    i_d_we = 1'b0;
    got = o_d_rdata; exp = exp_q.pop_front();
    chk_cnt++; if (got !== exp) $display("FAIL rd_first: got %h exp %h", got, exp); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      i_d_addr = (i == 0) ? 32'h8 : (i == 1) ? 32'hC : 32'h0;
      exp_q.push_back(dmem_m[i_d_addr[7:2]]);
      tick();
      got = o_d_rdata; exp = exp_q.pop_front();
      chk_cnt++; if (got !== exp) $display("FAIL d_read[%h]: got %h exp %h", i_d_addr, got, exp); else pass_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      idx = $urandom_range(40, 47); val = $urandom;
      i_d_we = 1'b1; i_d_addr = idx * 4; i_d_wdata = val;
      dmem_m[idx] = val;
      tick();
      i_d_we = 1'b0;
      exp_q.push_back(dmem_m[idx]);
      tick();
      got = o_d_rdata; exp = exp_q.pop_front();
      chk_cnt++; if (got !== exp) $display("FAIL rand_rw[%0d]: got %h exp %h", idx, got, exp); else pass_cnt++;
    end
    i_d_addr = 32'h0;
    chk_cnt++; if (o_err !== 1'b0) $display("FAIL data_no_err: got %0h exp 0", o_err); else pass_cnt++;
    finish_run(2'd3);
  endtask

  task automatic test_status_stream();
    logic [31:0] got, exp;
    logic [1:0]  codes [5];
    logic        vals  [5];
    logic [31:0] dump_idx [6];
    codes = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd3};
    vals  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    start_run();
    for (int i = 0; i < 5; i++) begin
      i_status = codes[i]; i_status_valid = vals[i];
      tick();
    end
    i_status_valid = 1'b0; i_status = 2'd0;
    chk_cnt++; if (o_inst_cnt !== 32'd3) $display("FAIL st_inst_cnt: got %0d exp 3", o_inst_cnt); else pass_cnt++;
    chk_cnt++; if ({o_done, o_end_code, o_timeout} !== 4'b1110) $display("FAIL st_done_code: got %b exp 1110", {o_done, o_end_code, o_timeout}); else pass_cnt++;
    chk_cnt++; if (o_core_rst_n !== 1'b1) $display("FAIL st_core_rst_lat: got %0h exp 1", o_core_rst_n); else pass_cnt++;
    // Statuses and start in DONE: no effect
    i_status = 2'd0; i_status_valid = 1'b1; i_start = 1'b1;
    tick();
    i_status_valid = 1'b0; i_start = 1'b0;
    chk_cnt++; if (o_core_rst_n !== 1'b0) $display("FAIL st_core_rst_fall: got %0h exp 0", o_core_rst_n); else pass_cnt++;
    tick();
    chk_cnt++; if ({o_inst_cnt, o_done, o_ld_ready} !== {32'd3, 1'b1, 1'b0}) $display("FAIL done_hold: got %h exp %h", {o_inst_cnt, o_done, o_ld_ready}, {32'd3, 1'b1, 1'b0}); else pass_cnt++;
    dump_idx = '{0, 2, 3, 36, 44, 70};
    for (int i = 0; i < 6; i++) begin
      i_dump_addr = dump_idx[i];
      exp_q.push_back(dump_idx[i] < 64 ? dmem_m[dump_idx[i]] : 32'h0);
      tick();
      got = o_dump_data; exp = exp_q.pop_front();
      chk_cnt++; if (got !== exp) $display("FAIL done_dump[%0d]: got %h exp %h", dump_idx[i], got, exp); else pass_cnt++;
    end
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    chk_cnt++; if ({o_ld_ready, o_done, o_end_code, o_inst_cnt} !== {1'b1, 1'b0, 2'd0, 32'd0}) $display("FAIL clear_state: got %h exp %h", {o_ld_ready, o_done, o_end_code, o_inst_cnt}, {1'b1, 1'b0, 2'd0, 32'd0}); else pass_cnt++;
  endtask

  task automatic test_overflow();
    // Terminal status in LOAD is ignored
    i_status = 2'd2; i_status_valid = 1'b1;
    tick();
    i_status_valid = 1'b0;
    chk_cnt++; if ({o_done, o_end_code} !== 3'b000) $display("FAIL load_status_ign: got %b exp 000", {o_done, o_end_code}); else pass_cnt++;
    start_run();
    tick();
    i_status = 2'd2; i_status_valid = 1'b1;
    tick();
    i_status_valid = 1'b0; i_status = 2'd0;
    chk_cnt++; if ({o_done, o_end_code, o_timeout} !== 4'b1100) $display("FAIL ovf_code: got %b exp 1100", {o_done, o_end_code, o_timeout}); else pass_cnt++;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] got, exp;
    start_run();
    tick();
    i_i_addr = 32'h402;
    exp_q.push_back(32'h0);
    tick();
    i_i_addr = 32'h0;
    got = o_i_inst; exp = exp_q.pop_front();
    chk_cnt++; if (got !== exp) $display("FAIL ill_fetch_data: got %h exp %h", got, exp); else pass_cnt++;
    chk_cnt++; if ({o_err, o_err_addr} !== {1'b1, 32'h402}) $display("FAIL ill_err_addr: got %h exp %h", {o_err, o_err_addr}, {1'b1, 32'h402}); else pass_cnt++;
    // Out-of-range write: dropped, reads 0, first error address kept
    i_d_we = 1'b1; i_d_addr = 32'h100; i_d_wdata = 32'h5555_5555;
    exp_q.push_back(32'h0);
    tick();
    i_d_we = 1'b0;
    got = o_d_rdata; exp = exp_q.pop_front();
    chk_cnt++; if (got !== exp) $display("FAIL ill_dread: got %h exp %h", got, exp); else pass_cnt++;
    i_d_addr = 32'h9;   // misaligned read of a word that holds nonzero data
    exp_q.push_back(32'h0);
    tick();
    i_d_addr = 32'h0;
    got = o_d_rdata; exp = exp_q.pop_front();
    chk_cnt++; if (got !== exp) $display("FAIL ill_misalign: got %h exp %h", got, exp); else pass_cnt++;
    chk_cnt++; if (o_err_addr !== 32'h402) $display("FAIL ill_first_kept: got %h exp 402", o_err_addr); else pass_cnt++;
    i_status = 2'd1; i_status_valid = 1'b1;
    tick();
    i_status_valid = 1'b0; i_status = 2'd0;
    chk_cnt++; if ({o_done, o_core_rst_n, o_inst_cnt} !== {1'b0, 1'b1, 32'd1}) $display("FAIL ill_continue: got %h exp %h", {o_done, o_core_rst_n, o_inst_cnt}, {1'b0, 1'b1, 32'd1}); else pass_cnt++;
    finish_run(2'd3);
    chk_cnt++; if (o_err !== 1'b0) $display("FAIL ill_err_clear: got %0h exp 0", o_err); else pass_cnt++;
    i_dump_addr = 0;
    exp_q.push_back(dmem_m[0]);
    tick();
    got = o_dump_data; exp = exp_q.pop_front();
    chk_cnt++; if (got !== exp) $display("FAIL ill_dmem_kept: got %h exp %h", got, exp); else pass_cnt++;
  endtask

  task automatic test_watchdog();
    int n;
    n = 0;
    start_run();
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (o_done === 1'b1) begin
        n = i;
        break;
      end
    end
    chk_cnt++; if (n != 20) $display("FAIL wd_cycles: got %0d exp 20", n); else pass_cnt++;
    chk_cnt++; if ({o_timeout, o_done, o_end_code} !== 4'b1100) $display("FAIL wd_flags: got %b exp 1100", {o_timeout, o_done, o_end_code}); else pass_cnt++;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    chk_cnt++; if ({o_ld_ready, o_timeout, o_done, o_inst_cnt} !== {3'b100, 32'd0}) $display("FAIL wd_clear: got %h exp %h", {o_ld_ready, o_timeout, o_done, o_inst_cnt}, {3'b100, 32'd0}); else pass_cnt++;
    // Watchdog restarts from zero on the next run
    start_run();
    for (int i = 0; i < 10; i++) tick();
    chk_cnt++; if (o_done !== 1'b0) $display("FAIL wd_restart: got %0h exp 0", o_done); else pass_cnt++;
    finish_run(2'd3);
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] got, exp;
    start_run();
    i_status = 2'd0; i_status_valid = 1'b1;
    tick();
    i_status_valid = 1'b0;
    i_i_addr = 32'h3; i_d_addr = 32'hC; i_dump_addr = 3;
    tick();
    i_i_addr = 32'h0;
    tick();
    #3;
    i_rst_n = 1'b0;
    #1;
    chk_cnt++; if ({o_ld_ready, o_core_rst_n} !== 2'b10) $display("FAIL mid_rst_ctrl: got %b exp 10", {o_ld_ready, o_core_rst_n}); else pass_cnt++;
    chk_cnt++; if ({o_i_inst, o_d_rdata, o_dump_data} !== 96'h0) $display("FAIL mid_rst_data: got %h exp 0", {o_i_inst, o_d_rdata, o_dump_data}); else pass_cnt++;
    chk_cnt++; if ({o_done, o_end_code, o_timeout, o_err, o_inst_cnt, o_err_addr} !== 69'h0) $display("FAIL mid_rst_stat: got %h exp 0", {o_done, o_end_code, o_timeout, o_err, o_inst_cnt, o_err_addr}); else pass_cnt++;
    chk_cnt++; if (dut.state_q !== 2'd0) $display("FAIL mid_rst_state: got %0d exp 0", dut.state_q); else pass_cnt++;
    i_d_addr = 32'h0; i_dump_addr = 0;
    tick();
    #3;
    i_rst_n = 1'b1;
    tick();
    start_run();
    tick();
    chk_cnt++; if (o_core_rst_n !== 1'b1) $display("FAIL post_rst_start: got %0h exp 1", o_core_rst_n); else pass_cnt++;
    i_i_addr = 32'h0;
    exp_q.push_back(imem_m[0]);
    tick();
    got = o_i_inst; exp = exp_q.pop_front();
    chk_cnt++; if (got !== exp) $display("FAIL post_rst_fetch: got %h exp %h", got, exp); else pass_cnt++;
    finish_run(2'd3);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_preload_fetch();
    test_data_path();
    test_status_stream();
    test_overflow();
    test_illegal();
    test_watchdog();
    test_reset_mid_run();
    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL sb_leftover: got %0d entries exp 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
